// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round subkey per valid/ready transfer,
// K1..K16 for encryption or K16..K1 for decryption.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    output logic        busy,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Tables use DES 1-based bit numbering (DES bit 1 is the MSB).
    localparam int unsigned Pc1Tab [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned Pc2Tab [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit i set where the per-round rotation amount is 2 instead of 1.
    localparam logic [15:0] ShiftTwo = 16'b0111_1110_1111_1100;

    state_e      state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  rnd_q;
    logic        mode_q;

    logic [55:0] cd0;
    logic [47:0] pc2_out;
    logic        enc_two, dec_two;
    logic        unused_parity;

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8], key_in[0]};

    always_comb begin
        cd0 = '0;
        for (int i = 0; i < 56; i++) begin
            cd0[55-i] = key_in[64-Pc1Tab[i]];
        end
    end

    always_comb begin
        pc2_out = '0;
        for (int i = 0; i < 48; i++) begin
            pc2_out[47-i] = ({c_q, d_q} >> (56 - Pc2Tab[i])) & 56'd1 ? 1'b1 : 1'b0;
        end
    end

    assign enc_two = ShiftTwo[rnd_q + 4'd1];
    assign dec_two = ShiftTwo[4'd15 - rnd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        // Decrypt starts at C16/D16, which equals C0/D0 after 28 total shifts.
                        c_q     <= decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
                        d_q     <= decrypt ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
                        rnd_q   <= '0;
                        mode_q  <= decrypt;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (subkey_ready) begin
                        if (rnd_q == 4'd15) begin
                            state_q <= StDone;
                        end else begin
                            rnd_q <= rnd_q + 4'd1;
                            if (mode_q) begin
                                c_q <= rotr(c_q, dec_two);
                                d_q <= rotr(d_q, dec_two);
                            end else begin
                                c_q <= rotl(c_q, enc_two);
                                d_q <= rotl(d_q, enc_two);
                            end
                        end
                    end
                end
                StDone: begin
                    rnd_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy         = (state_q != StIdle);
    assign subkey_valid = (state_q == StRun);
    assign done         = (state_q == StDone);
    assign round_idx    = rnd_q;
    assign subkey       = subkey_valid ? pc2_out : 48'd0;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: known-answer table, directed corner sequences and
// randomized keys/backpressure against a direct from-definition DES key model.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        done;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;

    localparam int Pc1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int Pc2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [63:0] key;
        logic        dec;
        int          idx;
        logic [47:0] exp;
    } vec_t;

    int          checks;
    int          errors;
    logic [47:0] got [16];
    logic [47:0] enc_seq [16];
    logic [47:0] par_seq [16];
    int          done_cyc;
    int          n_xfer;

    // K_round (1..16) from the DES definition: PC-1, cumulative left rotation, PC-2.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int round);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] r;
        int          s;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-Pc1[i]];
            d[27-i] = k[64-Pc1[28+i]];
        end
        s = 0;
        for (int i = 0; i < round; i++) s += Shifts[i];
        s = s % 28;
        c = (c << s) | (c >> (28 - s));
        d = (d << s) | (d >> (28 - s));
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-Pc2[i]];
        return r;
    endfunction

    function automatic logic [47:0] ref_nth(input logic [63:0] k, input logic dec, input int n);
        return ref_subkey(k, dec ? 16 - n : n + 1);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one full schedule and records the transferred subkeys in got[].
    // stall_idx/stall_len hold ready low at a given round; inject_idx pulses start mid-run.
    task automatic run_sched(input logic [63:0] k, input logic dec, input int stall_idx,
                             input int stall_len, input bit rand_ready, input int inject_idx);
        int          cyc;
        int          stalls;
        bit          prev_stall;
        logic [3:0]  prev_idx;
        logic [47:0] prev_key;
        @(negedge clk);
        key_in = k; decrypt = dec; start = 1'b1; subkey_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; stalls = 0; prev_stall = 1'b0; prev_idx = '0; prev_key = '0;
        n_xfer = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 400) begin
            cyc++;
            start = 1'b0;
            if (prev_stall)
                check("stall_hold", {11'd0, subkey_valid, round_idx, subkey},
                      {11'd0, 1'b1, prev_idx, prev_key});
            if (done) begin
                done_cyc = cyc;
                prev_stall = 1'b0;
                check("done_excl", {62'd0, busy, subkey_valid}, 64'd2);
            end else begin
                check("run_state", {58'd0, busy, subkey_valid, round_idx},
                      {58'd0, 1'b1, 1'b1, 4'(n_xfer)});
                if (stall_idx == n_xfer && stalls < stall_len) begin
                    subkey_ready = 1'b0;
                    stalls++;
                end else if (rand_ready) begin
                    subkey_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    subkey_ready = 1'b1;
                end
                if (inject_idx == n_xfer) begin
                    start = 1'b1; key_in = '0; decrypt = ~dec;
                end
                prev_stall = ~subkey_ready;
                prev_idx = round_idx;
                prev_key = subkey;
                if (subkey_ready && n_xfer < 16) begin
                    got[n_xfer] = subkey;
                    n_xfer++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        subkey_ready = 1'b1;
        check("n_transfers", 64'(n_xfer), 64'd16);
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        check("idle_after_done", {57'd0, busy, subkey_valid, done, round_idx}, 64'd0);
        check("idle_subkey_zero", {16'd0, subkey}, 64'd0);
    endtask

    task automatic check_seq(input string name, input logic [63:0] k, input logic dec);
        for (int i = 0; i < 16; i++) check(name, {16'd0, got[i]}, {16'd0, ref_nth(k, dec, i)});
    endtask

    vec_t vecs [6];

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; key_in = '0; decrypt = 1'b0; subkey_ready = 1'b1;

        #1;
        check("reset_outputs", {9'd0, busy, subkey_valid, done, round_idx, subkey}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Known-answer table.
        vecs[0] = '{KeyA, 1'b0, 0,  48'h1B02EFFC7072};
        vecs[1] = '{KeyA, 1'b0, 1,  48'h79AED9DBC9E5};
        vecs[2] = '{KeyA, 1'b0, 15, 48'hCB3D8B0E17F5};
        vecs[3] = '{KeyA, 1'b1, 0,  48'hCB3D8B0E17F5};
        vecs[4] = '{KeyA, 1'b1, 14, 48'h79AED9DBC9E5};
        vecs[5] = '{KeyA, 1'b1, 15, 48'h1B02EFFC7072};
        for (int v = 0; v < 6; v++) begin
            run_sched(vecs[v].key, vecs[v].dec, -1, 0, 1'b0, -1);
            check("kat_subkey", {16'd0, got[vecs[v].idx]}, {16'd0, vecs[v].exp});
            check("kat_done_cycle", 64'(done_cyc), 64'd17);
        end

        // Full encrypt, then decrypt must be its exact reverse.
        run_sched(KeyA, 1'b0, -1, 0, 1'b0, -1);
        check_seq("enc_seq", KeyA, 1'b0);
        for (int i = 0; i < 16; i++) enc_seq[i] = got[i];
        run_sched(KeyA, 1'b1, -1, 0, 1'b0, -1);
        for (int i = 0; i < 16; i++) check("dec_reverse", {16'd0, got[i]}, {16'd0, enc_seq[15-i]});

        // Backpressure at round 1 for 3 cycles.
        run_sched(KeyA, 1'b0, 1, 3, 1'b0, -1);
        check_seq("stall_seq", KeyA, 1'b0);
        check("stall_done_cycle", 64'(done_cyc), 64'd20);

        // Start with a different key while busy must be ignored.
        run_sched(KeyA, 1'b0, -1, 0, 1'b0, 5);
        check_seq("busy_start_seq", KeyA, 1'b0);

        // Reset mid-run.
        begin
            int cyc;
            @(negedge clk);
            key_in = KeyA; decrypt = 1'b0; start = 1'b1; subkey_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0;
            while (round_idx != 4'd7 && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("reach_idx7", {60'd0, round_idx}, 64'd7);
            rst = 1'b1;
            #1;
            check("rst_async", {9'd0, busy, subkey_valid, done, round_idx, subkey}, 64'd0);
            @(negedge clk);
            check("rst_held", {9'd0, busy, subkey_valid, done, round_idx, subkey}, 64'd0);
            rst = 1'b0; key_in = KeyA; start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check("first_after_rst", {11'd0, subkey_valid, round_idx, subkey},
                  {11'd0, 1'b1, 4'd0, 48'h1B02EFFC7072});
            cyc = 0;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("rst_run_done", 64'(done), 64'd1);
            @(negedge clk);
        end

        // Parity bits must not matter.
        run_sched(64'h123456789ABCDEF0, 1'b0, -1, 0, 1'b0, -1);
        for (int i = 0; i < 16; i++) par_seq[i] = got[i];
        check_seq("parity_a_seq", 64'h123456789ABCDEF0, 1'b0);
        run_sched(64'h133557799BBDDFF1, 1'b0, -1, 0, 1'b0, -1);
        for (int i = 0; i < 16; i++) check("parity_match", {16'd0, got[i]}, {16'd0, par_seq[i]});

        // Random keys, modes and backpressure.
        for (int r = 0; r < 8; r++) begin
            logic [63:0] k;
            logic        d;
            k = {$urandom(), $urandom()};
            d = 1'($urandom_range(0, 1));
            run_sched(k, d, -1, 0, 1'b1, -1);
            check_seq("rand_seq", k, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key schedule. It accepts a 64-bit key and produces the sixteen 48-bit round subkeys, one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1). It sits directly upstream of `fFunction` and feeds its 48-bit `key` input through the round controller, which consumes one subkey per round using a valid/ready handshake.

## Interface
- No parameters; all widths are fixed by DES.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new schedule; sampled only in IDLE.
- `key_in`  in  64  DES key; bit 63 = DES bit 1; parity bits (DES 8,16,…,64) are ignored.
- `decrypt`  in  1  sampled with `start`; 0 = K1→K16, 1 = K16→K1.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `subkey`  out  48  current subkey; bit 47 = DES bit 1.
- `subkey_valid`  out  1  `subkey` is valid.
- `subkey_ready`  in  1  downstream accepts `subkey` this cycle.
- `round_idx`  out  4  index of the current subkey, 0..15 (0 = first delivered).
- `done`  out  1  one-cycle pulse after the 16th transfer.

## Operation
- **States:** IDLE, RUN, DONE.
- **Registers:** C[27:0], D[27:0], round counter rnd[3:0], mode bit.
- **IDLE → RUN** when `start` = 1.
  - {C0, D0} = PC-1(`key_in`).
  - Encrypt: C/D are loaded with C0/D0 rotated left by 1 (i.e. C1/D1).
  - Decrypt: C/D are loaded with C0/D0 unrotated (C16 = C0).
  - rnd ← 0; mode ← `decrypt`.
- **In RUN:**
  - `subkey` = PC-2(C, D), combinational from the registers.
  - `subkey_valid` = 1.
  - `round_idx` = rnd.
- **Transfer** occurs on a cycle where `subkey_valid` && `subkey_ready`.
  - If rnd < 15: rnd increments.
    - Encrypt: C and D rotate left by SHIFT[rnd+1].
    - Decrypt: C and D rotate right by SHIFT[15−rnd].
  - If rnd = 15: go to DONE.
- **SHIFT table**, indexed 0..15: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Rotations act independently on each 28-bit half, with wrap-around within the half.
- **DONE:** `done` = 1 for one cycle, then IDLE. `subkey_valid` = 0.
- **Stall:** while `subkey_ready` = 0 in RUN, `subkey`, `round_idx` and C/D hold stable. `subkey_valid` never drops before the transfer.
- **Start while busy:** `start` is ignored in RUN and DONE. A new `key_in` has no effect mid-schedule.
- **Reset** (asserted at any time, including mid-RUN):
  - Outputs go immediately to reset values: `busy`=0, `subkey_valid`=0, `done`=0, `round_idx`=0, `subkey`=0.
  - C/D = 0; state = IDLE.
  - No partial schedule resumes after reset.
- **Subkey gating:** `subkey` is forced to 0 whenever `subkey_valid` = 0.

## Timing
- **Start acceptance:** `start` is sampled on edge T in IDLE. K(first) is valid at T+1 with `round_idx`=0.
- **Throughput:** with `subkey_ready` held high, one subkey per cycle.
  - The 16th subkey is valid at T+16.
  - `done` pulses at T+17.
  - IDLE is reached at T+18, and `start` can be accepted there.
- **Latency:** start to first subkey is 1 cycle. Each transfer advances the output on the following edge.
- **`busy`:** equals (state ≠ IDLE).
- **`done` and `subkey_valid`:** never high in the same cycle.
- **Reset release:** the first `start` is honoured on the first rising edge after `rst` deasserts.

## Test plan
- **Encrypt, ready tied high:** `key_in`=0x133457799BBCDFF1, `decrypt`=0, `start` pulse.
  - `round_idx`0 `subkey`=0x1B02EFFC7072.
  - `round_idx`1 = 0x79AED9DBC9E5.
  - `round_idx`15 = 0xCB3D8B0E17F5.
  - `done` at T+17.
- **Decrypt, same key:** `round_idx`0 = 0xCB3D8B0E17F5, `round_idx`14 = 0x79AED9DBC9E5, `round_idx`15 = 0x1B02EFFC7072.
  - Full sequence is the exact reverse of the encrypt run.
- **Backpressure:** encrypt, `subkey_ready` low for 3 cycles at `round_idx`=1.
  - `subkey` holds 0x79AED9DBC9E5 and `subkey_valid` stays 1.
  - Sequence resumes correctly; `done` is delayed by 3 cycles.
- **Start while busy:** assert `start` with key 0 at `round_idx`=5.
  - All 16 subkeys still match key 0x133457799BBCDFF1.
- **Reset mid-run:** assert `rst` at `round_idx`=7.
  - All outputs are 0 before the next clock edge.
  - After release, a new start reproduces K1=0x1B02EFFC7072.
- **Parity independence:** `key_in`=0x123456789ABCDEF0 vs 0x133557799BBDDFF1 (parity LSBs flipped).
  - Both produce identical subkey sequences.
